// File: rtl/rx_sample_packer.sv
// Frames RX DSP samples into SOF/EOF packets and buffers them in a show-ahead FIFO; optional RX_PACKER_OVF_COUNT_EN adds a saturating overflow counter.
// Latency: a strobe at cycle N reaches data_o with src_rdy_o=1 at N+1 when the FIFO was empty.
// Backpressure: dst_rdy_i low fills the FIFO; a strobe while full drops the sample, stops the core and closes the open packet.

module rx_packer_fifo #(
    parameter int W  = 34,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Caller only pushes when not full and pops when not empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
endmodule

module rx_sample_packer #(
    parameter int BASE    = 176,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] sample,
    input  logic        strobe,
    output logic        run,
    output logic [33:0] data_o,
    output logic        src_rdy_o,
    input  logic        dst_rdy_i,
    output logic        overflow,
    output logic [15:0] ovf_count,
    output logic [31:0] debug
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] ADDR_SPP = BASE[7:0];
    localparam logic [7:0] ADDR_CMD = ADDR_SPP + 8'd1;

    state_t        state, state_next;
    logic [15:0]   spp_reg, spp_cur, pkt_cnt;
    logic [15:0]   spp_sel, spp_lim;
    logic          continuous;
    logic [27:0]   nsamps_rem;
    logic          sof_pending, stop_pending, run_q;

    logic          wr_spp, wr_cmd, cmd_start, cmd_cont, start_ok;
    logic [27:0]   cmd_nsamps;
    logic          pkt_last, burst_last, samp_eof;
    logic          push, samp_push, ovf_evt, accept_start, pop;
    logic [33:0]   push_dat;
    logic [FIFO_AW:0] fifo_cnt;
    logic          fifo_empty, fifo_full;
    logic          unused_cmd_bits;

    assign wr_spp     = set_stb && (set_addr == ADDR_SPP);
    assign wr_cmd     = set_stb && (set_addr == ADDR_CMD);
    assign cmd_start  = set_data[31];
    assign cmd_cont   = set_data[30];
    assign cmd_nsamps = set_data[27:0];
    assign start_ok   = wr_cmd && cmd_start && (cmd_cont || (cmd_nsamps != 28'd0));
    assign unused_cmd_bits = &{1'b0, set_data[29:28]};

    // Packet length is sampled at SOF, so an spp write mid-packet waits for the next one.
    assign spp_sel    = sof_pending ? spp_reg : spp_cur;
    assign spp_lim    = (spp_sel == 16'd0) ? 16'd1 : spp_sel;
    assign pkt_last   = (({1'b0, pkt_cnt} + 17'd1) == {1'b0, spp_lim});
    assign burst_last = !continuous && (nsamps_rem == 28'd1);
    assign samp_eof   = pkt_last || burst_last;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        push         = 1'b0;
        samp_push    = 1'b0;
        push_dat     = '0;
        ovf_evt      = 1'b0;
        accept_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    accept_start = 1'b1;
                    state_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (strobe) begin
                    // Registered count: a pop this cycle does not make room.
                    if (fifo_full) begin
                        ovf_evt    = 1'b1;
                        state_next = ST_FLUSH;
                    end else begin
                        push      = 1'b1;
                        samp_push = 1'b1;
                        push_dat  = {samp_eof, sof_pending, sample};
                        if (samp_eof && (burst_last || stop_pending))
                            state_next = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (!sof_pending) begin
                    if (!fifo_full) begin
                        push     = 1'b1;
                        push_dat = {1'b1, 1'b0, 32'h0};
                    end
                end else if (fifo_empty) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q        <= 1'b0;
            overflow     <= 1'b0;
            spp_reg      <= 16'd0;
            spp_cur      <= 16'd0;
            pkt_cnt      <= 16'd0;
            continuous   <= 1'b0;
            nsamps_rem   <= 28'd0;
            sof_pending  <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            run_q    <= (state_next == ST_RUN);
            overflow <= ovf_evt;
            if (wr_spp) spp_reg <= set_data[15:0];

            if (accept_start) begin
                continuous  <= cmd_cont;
                nsamps_rem  <= cmd_nsamps;
                sof_pending <= 1'b1;
                pkt_cnt     <= 16'd0;
            end else if (samp_push) begin
                nsamps_rem  <= nsamps_rem - 28'd1;
                if (sof_pending) spp_cur <= spp_reg;
                sof_pending <= samp_eof;
                pkt_cnt     <= samp_eof ? 16'd0 : pkt_cnt + 16'd1;
            end else if ((state == ST_FLUSH) && push) begin
                sof_pending <= 1'b1;
            end

            if (state_next != ST_RUN)
                stop_pending <= 1'b0;
            else if ((state == ST_RUN) && wr_cmd && !cmd_start)
                stop_pending <= 1'b1;
        end
    end

`ifdef RX_PACKER_OVF_COUNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || accept_start)
            ovf_cnt_q <= 16'h0000;
        else if (ovf_evt && (ovf_cnt_q != 16'hFFFF))
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 16'h0000;
`endif

    rx_packer_fifo #(.W(34), .AW(FIFO_AW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (data_o),
        .count    (fifo_cnt),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign src_rdy_o = !fifo_empty;
    assign pop       = src_rdy_o && dst_rdy_i;
    assign run       = run_q;
    assign debug     = {{(25 - FIFO_AW){1'b0}}, state, fifo_cnt,
                        sof_pending, stop_pending, run_q, strobe};
endmodule

// File: doc/rx_sample_packer.md
Name: rx_sample_packer

Overview:
- Downstream stage of the RX DSP core. Owns the core's `run` input and consumes its 32-bit `{I,Q}` sample plus `strobe`.
- Gates streaming from a stream-command setting register.
- Frames samples into packets with SOF/EOF flags and buffers them in a small FIFO.
- Presents 34-bit words on a src_rdy/dst_rdy handshake toward the RX packet FIFO chain. Detects overflow and closes truncated packets cleanly.

Parameters:
- BASE, 176, settings-bus base address. Uses BASE+0 (spp) and BASE+1 (stream command).
- FIFO_AW, 4, log2 of FIFO depth (16 words).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- set_stb  in  1  settings strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- sample  in  32  DSP sample, {I[15:0],Q[15:0]}
- strobe  in  1  sample valid, one-cycle pulses
- run  out  1  enable to DSP core
- data_o  out  34  {eof, sof, payload[31:0]}
- src_rdy_o  out  1  data_o valid
- dst_rdy_i  in  1  consumer ready
- overflow  out  1  one-cycle pulse per dropped sample
- ovf_count  out  16  overflow event count (see Optional Feature)
- debug  out  32  {state[1:0], fifo_count, sof_pending, stop_pending, run, strobe}

Behaviour:
- Reset values:
  - run=0, src_rdy_o=0, overflow=0, ovf_count=0, FIFO empty, state=IDLE.
  - spp=0, which behaves as 1.
- BASE+0 write: spp[15:0].
  - A value of 0 is treated as 1.
  - A write while running takes effect at the next SOF.
- BASE+1 write: bit31 start, bit30 continuous, bits[27:0] nsamps.
- IDLE:
  - start=1 with (continuous or nsamps≠0) → RUN. Latch continuous/nsamps; sof_pending=1; run=1 from the next cycle.
  - start=1 with nsamps=0 and non-continuous is ignored.
- RUN:
  - Each strobe pushes `{eof, sof, sample}`.
  - sof = sof_pending; the push clears it.
  - eof=1 when the packet count reaches spp, or when the remaining nsamps reaches 1 (non-continuous).
  - After an eof push, sof_pending=1 and the packet counter resets.
  - Last burst sample pushed → IDLE, run=0 the next cycle.
  - Write with start=0 sets stop_pending. The next eof push → IDLE, clearing stop_pending.
  - Write with start=1 while in RUN is ignored.
- Overflow:
  - Condition: strobe while FIFO count == depth, using the registered count. A pop in the same cycle does not rescue the push.
  - Action: drop the sample, pulse overflow, run=0, → FLUSH.
- FLUSH:
  - If a packet was open (sof_pending=0), wait for not-full, then push `{eof=1, sof=0, 32'h0}`.
  - Then wait for FIFO empty → IDLE.
  - Strobes arriving in FLUSH are ignored and do not pulse overflow.
- FIFO:
  - Show-ahead.
  - src_rdy_o = not empty; pop on src_rdy_o & dst_rdy_i.
  - Latency: strobe at cycle N → word on data_o with src_rdy_o=1 at N+1, when the FIFO was empty.
  - Simultaneous push and pop when not full: count unchanged.
- Counters:
  - Packet counter is 16 bits.
  - nsamps counter is 28 bits and decrements on each accepted push.
- Reset mid-packet: FIFO flushed immediately, no EOF emitted, all state to reset values.

Optional Feature:
- Macro: RX_PACKER_OVF_COUNT_EN.
- Defined:
  - ovf_count increments on each overflow pulse, saturating at 16'hFFFF.
  - Cleared by rst or by any BASE+1 write with start=1 accepted from IDLE.
- Undefined: ovf_count tied to 16'h0000; no counter logic.

Test Plan:
- spp=4, cmd start, nsamps=8, dst_rdy_i=1, 8 strobes of 0x00010002+k → 2 packets: sof on words 0 and 4, eof on words 3 and 7; run falls one cycle after the 8th push.
- spp=3, continuous, stop written after sample 4 → samples 5 and 6 still pushed, eof on word 5; IDLE, no further pushes.
- dst_rdy_i=0, continuous, spp=100, 17 strobes → 16 buffered, overflow pulses once, run=0. Release dst_rdy_i → 16 words, then `{eof=1, sof=0, 0}`, then IDLE. ovf_count=1 with macro defined, 0 without.
- Strobe while full with a simultaneous pop → still an overflow; the sample is dropped.
- spp=0, nsamps=2 → two packets of 1 word, each with sof=eof=1.
- rst asserted mid-packet with 5 words buffered → next cycle src_rdy_o=0, run=0, state IDLE; a new start command produces a fresh SOF.
